// File: rtl/spi_baud_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_baud_gen_pkg
//  Description : Shared definitions for the SPI baud-rate generator:
//                FSM state encoding and SPIBR field placement helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_baud_gen_pkg;

    // Frame sequencer states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // SPIBR layout: SPR at the bottom, one reserved bit, then SPPR, then
    // one reserved bit at the top.
    localparam int SPR_LSB = 0;

    function automatic int sppr_lsb(input int spr_w);
        return spr_w + 1;
    endfunction

    function automatic int br_reg_width(input int sppr_w, input int spr_w);
        return sppr_w + spr_w + 2;
    endfunction

endpackage : spi_baud_gen_pkg
`default_nettype wire

// File: rtl/spi_baud_gen_br_reg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_baud_gen_br_reg
//  Description : SPIBR register. Writes are accepted only while the frame
//                sequencer is idle; reserved bits always store 0.
//  Ports       : clk, rst_n       clock / async active-low reset
//                i_we, i_wdata    write strobe and data
//                i_idle           write enable gate (sequencer idle)
//                o_rdata          register readback
//                o_spr, o_sppr    decoded shift and prescaler fields
//  Revision    : 1.0  initial release
// ============================================================================
module spi_baud_gen_br_reg
    import spi_baud_gen_pkg::*;
#(
    parameter int SPPR_W = 3,
    parameter int SPR_W  = 3,
    parameter int REG_W  = SPPR_W + SPR_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [REG_W-1:0]  i_wdata,
    input  logic              i_idle,
    output logic [REG_W-1:0]  o_rdata,
    output logic [SPR_W-1:0]  o_spr,
    output logic [SPPR_W-1:0] o_sppr
);

    // Reserved bit positions: the gap above SPR and the MSB.
    localparam logic [REG_W-1:0] c_RSVD_MASK =
        (REG_W'(1) << SPR_W) | (REG_W'(1) << (REG_W - 1));

    logic [REG_W-1:0] r_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg <= '0;
        end else if (i_we && i_idle) begin
            r_reg <= i_wdata & ~c_RSVD_MASK;
        end
    end

    assign o_rdata = r_reg;
    assign o_spr   = r_reg[SPR_LSB +: SPR_W];
    assign o_sppr  = r_reg[sppr_lsb(SPR_W) +: SPPR_W];

endmodule : spi_baud_gen_br_reg
`default_nettype wire

// File: rtl/spi_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_baud_gen
//  Description : SPI baud-rate generator. SCK half-period is
//                (SPPR+1)*2^SPR clk cycles; each start runs one frame of
//                2*DATA_W SCK toggles with lead/trail strobes and a done
//                pulse on the final toggle.
//  Ports       : clk, rst_n                 clock / async active-low reset
//                i_br_we, i_br_wdata        SPIBR write port
//                o_br_rdata                 SPIBR readback
//                i_cpol                     idle clock level
//                i_start, i_abort           frame control
//                o_busy                     frame in progress
//                o_sck                      serial clock (registered)
//                o_lead_edge, o_trail_edge  odd / even SCK toggle strobes
//                o_done                     end-of-frame strobe
//  Revision    : 1.0  initial release
// ============================================================================
module spi_baud_gen
    import spi_baud_gen_pkg::*;
#(
    parameter  int SPPR_W = 3,
    parameter  int SPR_W  = 3,
    parameter  int DATA_W = 8,
    localparam int REG_W  = SPPR_W + SPR_W + 2,
    localparam int CNT_W  = SPPR_W + 2**SPR_W - 1,
    localparam int EC_W   = $clog2(2*DATA_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_br_we,
    input  logic [REG_W-1:0] i_br_wdata,
    output logic [REG_W-1:0] o_br_rdata,
    input  logic             i_cpol,
    input  logic             i_start,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_sck,
    output logic             o_lead_edge,
    output logic             o_trail_edge,
    output logic             o_done
);

    localparam logic [EC_W-1:0] c_LAST_EDGE = EC_W'(2*DATA_W - 1);

    logic [SPR_W-1:0]  w_spr;
    logic [SPPR_W-1:0] w_sppr;
    logic [CNT_W-1:0]  w_half_m1;

    state_t            r_state,    w_state_nxt;
    logic [CNT_W-1:0]  r_cnt,      w_cnt_nxt;
    logic [CNT_W-1:0]  r_half_m1,  w_half_m1_nxt;
    logic [EC_W-1:0]   r_edge_cnt, w_edge_cnt_nxt;
    logic              r_sck,      w_sck_nxt;
    logic              r_lead,     w_lead_nxt;
    logic              r_trail,    w_trail_nxt;
    logic              r_done,     w_done_nxt;
    logic              r_cpol_q,   w_cpol_q_nxt;

    spi_baud_gen_br_reg #(
        .SPPR_W (SPPR_W),
        .SPR_W  (SPR_W),
        .REG_W  (REG_W)
    ) u_br_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (i_br_we),
        .i_wdata (i_br_wdata),
        .i_idle  (r_state == ST_IDLE),
        .o_rdata (o_br_rdata),
        .o_spr   (w_spr),
        .o_sppr  (w_sppr)
    );

    // half-1 = ((SPPR+1) << SPR) - 1 = (SPPR << SPR) + (2^SPR - 1).
    // The two terms occupy disjoint bits, so OR replaces the add and the
    // result always fits CNT_W without an intermediate wider value.
    assign w_half_m1 = (CNT_W'(w_sppr) << w_spr) |
                       ((CNT_W'(1) << w_spr) - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_half_m1  <= '0;
            r_edge_cnt <= '0;
            r_sck      <= 1'b0;
            r_lead     <= 1'b0;
            r_trail    <= 1'b0;
            r_done     <= 1'b0;
            r_cpol_q   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_half_m1  <= w_half_m1_nxt;
            r_edge_cnt <= w_edge_cnt_nxt;
            r_sck      <= w_sck_nxt;
            r_lead     <= w_lead_nxt;
            r_trail    <= w_trail_nxt;
            r_done     <= w_done_nxt;
            r_cpol_q   <= w_cpol_q_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_half_m1_nxt  = r_half_m1;
        w_edge_cnt_nxt = r_edge_cnt;
        w_sck_nxt      = r_sck;
        w_lead_nxt     = 1'b0;
        w_trail_nxt    = 1'b0;
        w_done_nxt     = 1'b0;
        w_cpol_q_nxt   = r_cpol_q;

        case (r_state)
            ST_IDLE: begin
                w_sck_nxt = i_cpol;
                if (i_start) begin
                    w_state_nxt    = ST_RUN;
                    w_cpol_q_nxt   = i_cpol;
                    w_cnt_nxt      = '0;
                    w_edge_cnt_nxt = '0;
                    // Divisor snapshot keeps the frame rate constant.
                    w_half_m1_nxt  = w_half_m1;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_state_nxt    = ST_IDLE;
                    w_sck_nxt      = r_cpol_q;
                    w_cnt_nxt      = '0;
                    w_edge_cnt_nxt = '0;
                end else if (r_cnt == r_half_m1) begin
                    w_cnt_nxt      = '0;
                    w_sck_nxt      = ~r_sck;
                    w_edge_cnt_nxt = r_edge_cnt + EC_W'(1);
                    // Toggle number = r_edge_cnt+1: odd -> lead, even -> trail.
                    w_lead_nxt     = ~r_edge_cnt[0];
                    w_trail_nxt    = r_edge_cnt[0];
                    if (r_edge_cnt == c_LAST_EDGE) begin
                        // Busy drops together with the final toggle so the
                        // frame occupies exactly 2*DATA_W half-periods.
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_busy       = (r_state == ST_RUN);
    assign o_sck        = r_sck;
    assign o_lead_edge  = r_lead;
    assign o_trail_edge = r_trail;
    assign o_done       = r_done;

endmodule : spi_baud_gen
`default_nettype wire

// File: tb/tb_spi_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_baud_gen
//  Description : Self-checking bench for spi_baud_gen. Expected frame
//                profiles are queued when a frame is started and popped
//                when the observed frame completes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_baud_gen;

    logic       clk;
    logic       rst_n;
    logic       br_we;
    logic [7:0] br_wdata;
    logic [7:0] br_rdata;
    logic       cpol;
    logic       start;
    logic       abort;
    logic       busy;
    logic       sck;
    logic       lead;
    logic       trail;
    logic       done;

    int checks;
    int failures;

    typedef struct packed {
        int   busy_len;
        int   first_tog;
        int   n_lead;
        int   n_trail;
        int   n_done;
        logic end_sck;
        logic done_on_trail;
    } frame_t;

    frame_t exp_q[$];

    spi_baud_gen #(
        .SPPR_W (3),
        .SPR_W  (3),
        .DATA_W (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_br_we      (br_we),
        .i_br_wdata   (br_wdata),
        .o_br_rdata   (br_rdata),
        .i_cpol       (cpol),
        .i_start      (start),
        .i_abort      (abort),
        .o_busy       (busy),
        .o_sck        (sck),
        .o_lead_edge  (lead),
        .o_trail_edge (trail),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: frame profile from the written register value.
    function automatic frame_t model_frame(input logic [7:0] v, input logic pol);
        frame_t f;
        int     half;
        half            = (int'(v[6:4]) + 1) << v[2:0];
        f.busy_len      = 16 * half;
        f.first_tog     = half;
        f.n_lead        = 8;
        f.n_trail       = 8;
        f.n_done        = 1;
        f.end_sck       = pol;
        f.done_on_trail = 1'b1;
        return f;
    endfunction

    task automatic wr(input logic [7:0] v);
        @(negedge clk);
        br_we    = 1'b1;
        br_wdata = v;
        @(negedge clk);
        br_we    = 1'b0;
    endtask

    // Observes one frame from busy rising to busy falling (bounded).
    task automatic measure(input bit hold_start, output frame_t obs,
                           output int pre_idle, output bit ok);
        int  cyc;
        bit  seen;
        obs      = '0;
        pre_idle = 0;
        ok       = 1'b1;
        seen     = 1'b0;
        @(negedge clk);
        while (!busy && pre_idle < 50) begin
            pre_idle++;
            @(negedge clk);
        end
        if (!busy) begin
            ok = 1'b0;
            return;
        end
        if (!hold_start) start = 1'b0;
        cyc = 0;
        while (busy && cyc < 5000) begin
            obs.busy_len++;
            if ((lead || trail) && !seen) begin
                obs.first_tog = obs.busy_len - 1;
                seen          = 1'b1;
            end
            if (lead)  obs.n_lead++;
            if (trail) obs.n_trail++;
            if (done)  obs.n_done++;
            @(negedge clk);
            cyc++;
        end
        if (busy) begin
            ok = 1'b0;
            return;
        end
        if (lead)  obs.n_lead++;
        if (trail) obs.n_trail++;
        if (done)  obs.n_done++;
        obs.end_sck       = sck;
        obs.done_on_trail = done && trail;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, sck, lead, trail, done} !== 5'b0 || br_rdata !== 8'h00) begin
            failures++;
            $display("FAIL reset: busy=%b sck=%b lead=%b trail=%b done=%b rdata=%h want all 0",
                     busy, sck, lead, trail, done, br_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_slow_frame;
        frame_t obs, exp_f;
        int     pre;
        bit     ok;
        wr(8'h1E);
        checks++;
        if (br_rdata !== 8'h16) begin
            failures++;
            $display("FAIL rdata_1e: got %h want 16", br_rdata);
        end
        cpol  = 1'b0;
        start = 1'b1;
        exp_q.push_back(model_frame(8'h1E, 1'b0));
        measure(1'b0, obs, pre, ok);
        exp_f = exp_q.pop_front();
        checks++;
        if (!ok || obs !== exp_f) begin
            failures++;
            $display("FAIL slow_frame: ok=%0b got len=%0d first=%0d lead=%0d trail=%0d done=%0d sck=%b dot=%b want len=%0d first=%0d",
                     ok, obs.busy_len, obs.first_tog, obs.n_lead, obs.n_trail, obs.n_done,
                     obs.end_sck, obs.done_on_trail, exp_f.busy_len, exp_f.first_tog);
        end
    endtask

    task automatic test_fast_frame;
        frame_t obs, exp_f;
        int     pre;
        bit     ok;
        wr(8'h00);
        cpol  = 1'b0;
        start = 1'b1;
        exp_q.push_back(model_frame(8'h00, 1'b0));
        measure(1'b0, obs, pre, ok);
        exp_f = exp_q.pop_front();
        checks++;
        if (!ok || obs !== exp_f) begin
            failures++;
            $display("FAIL fast_frame: ok=%0b got len=%0d first=%0d lead=%0d trail=%0d done=%0d sck=%b dot=%b want len=%0d first=%0d",
                     ok, obs.busy_len, obs.first_tog, obs.n_lead, obs.n_trail, obs.n_done,
                     obs.end_sck, obs.done_on_trail, exp_f.busy_len, exp_f.first_tog);
        end
    endtask

    task automatic test_reg_lock;
        int n;
        // Register currently holds 0x00 from the previous test.
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        br_we    = 1'b1;
        br_wdata = 8'h3A;
        @(negedge clk);
        br_we    = 1'b0;
        checks++;
        if (br_rdata !== 8'h00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reg_lock_busy: rdata=%h busy=%b want rdata=00 busy=1", br_rdata, busy);
        end
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reg_lock_wait: busy=%b want 0", busy);
        end
        wr(8'h3A);
        checks++;
        if (br_rdata !== 8'h32) begin
            failures++;
            $display("FAIL rdata_3a: got %h want 32", br_rdata);
        end
    endtask

    task automatic test_cpol_abort;
        int  n, edges;
        bit  saw_done;
        wr(8'h01);
        cpol = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (sck !== 1'b1) begin
            failures++;
            $display("FAIL idle_cpol1: sck=%b want 1", sck);
        end
        start = 1'b1;
        n = 0;
        @(negedge clk);
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        start    = 1'b0;
        cpol     = 1'b0;
        edges    = 0;
        saw_done = 1'b0;
        n        = 0;
        while (edges < 5 && n < 200) begin
            @(negedge clk);
            if (lead || trail) edges++;
            if (done) saw_done = 1'b1;
            n++;
        end
        checks++;
        if (edges != 5 || sck !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL five_edges: edges=%0d sck=%b busy=%b want 5 0 1", edges, sck, busy);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || sck !== 1'b1 || lead || trail || done) begin
            failures++;
            $display("FAIL abort: busy=%b sck=%b lead=%b trail=%b done=%b want 0 1 0 0 0",
                     busy, sck, lead, trail, done);
        end
        repeat (4) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL abort_no_done: done/busy seen=%b want 0", saw_done);
        end
        cpol = 1'b1;
        @(negedge clk);
        checks++;
        if (sck !== 1'b1) begin
            failures++;
            $display("FAIL idle_after_abort: sck=%b want 1", sck);
        end
    endtask

    task automatic test_async_reset;
        int n;
        wr(8'h01);
        cpol  = 1'b1;
        start = 1'b1;
        n = 0;
        @(negedge clk);
        while (!busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || sck !== 1'b0 || br_rdata !== 8'h00 || lead || trail || done) begin
            failures++;
            $display("FAIL async_reset: busy=%b sck=%b rdata=%h lead=%b trail=%b done=%b want all 0",
                     busy, sck, br_rdata, lead, trail, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        frame_t obs, exp_f;
        int     pre;
        bit     ok;
        int     n;
        wr(8'h00);
        cpol  = 1'b0;
        start = 1'b1;
        for (int f = 0; f < 3; f++) exp_q.push_back(model_frame(8'h00, 1'b0));
        for (int f = 0; f < 3; f++) begin
            measure(1'b1, obs, pre, ok);
            if (f == 2) start = 1'b0;
            exp_f = exp_q.pop_front();
            checks++;
            if (!ok || obs !== exp_f) begin
                failures++;
                $display("FAIL b2b_frame%0d: ok=%0b got len=%0d first=%0d lead=%0d trail=%0d done=%0d sck=%b dot=%b want len=%0d",
                         f, ok, obs.busy_len, obs.first_tog, obs.n_lead, obs.n_trail, obs.n_done,
                         obs.end_sck, obs.done_on_trail, exp_f.busy_len);
            end
            if (f > 0) begin
                checks++;
                if (pre != 0) begin
                    failures++;
                    $display("FAIL b2b_gap%0d: extra idle cycles=%0d want 0", f, pre);
                end
            end
        end
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stop: busy=%b want 0", busy);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        br_we    = 1'b0;
        br_wdata = 8'h00;
        cpol     = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        test_reset();
        test_slow_frame();
        test_fast_frame();
        test_reg_lock();
        test_cpol_abort();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spi_baud_gen
`default_nettype wire
